// File: rtl/sqrt_result_display_if.sv
// Result handshake between the square-root core and the display stage.
// The producer holds res_data/res_valid until it sees res_ready.
interface sqrt_result_display_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic [WIDTH-1:0] res_data;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output res_data,
        output res_valid,
        input  res_ready
    );

    modport slave (
        input  res_data,
        input  res_valid,
        output res_ready
    );
endinterface

// File: rtl/sqrt_result_display.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a time-multiplexed
// 7-segment display with leading-zero blanking; the display shows the committed value.
module sqrt_result_display #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned SCAN_DIV = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sqrt_result_display_if.slave  res,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BcdW = 4 * DIGITS;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [BcdW-1:0]     work_q, work_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [BcdW-1:0]     bcd_q, bcd_d;
    logic [SCAN_DIV-1:0] presc_q, presc_d;
    logic [IdxW-1:0]     idx_q, idx_d;

    logic [BcdW-1:0]       adj;
    logic [BcdW+WIDTH-1:0] shifted;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Conversion FSM: add-3 correction happens before the shift in the same cycle.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        adj     = work_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (work_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
            end
        end
        shifted = {adj, bin_q} << 1;

        unique case (state_q)
            StIdle: begin
                if (res.res_valid) begin
                    bin_d   = res.res_data;
                    work_d  = '0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                {work_d, bin_d} = shifted;
                cnt_d           = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                bcd_d   = work_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        res.res_ready = (state_q == StIdle);
        busy          = (state_q == StShift) || (state_q == StCommit);
    end

    // Free-running scan: the digit index advances when the prescaler wraps.
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == '1) begin
            idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    logic [DIGITS-1:0] blank;
    logic              higher_zero;
    logic [3:0]        cur_nib;
    logic              cur_blank;

    // Digit k>0 is blanked when it and every digit above it are zero.
    always_comb begin
        blank       = '0;
        higher_zero = 1'b1;
        cur_nib     = '0;
        cur_blank   = 1'b0;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            higher_zero = higher_zero & (bcd_q[4*k +: 4] == 4'd0);
            blank[k]    = higher_zero;
        end
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (idx_q == IdxW'(k)) begin
                cur_nib   = bcd_q[4*k +: 4];
                cur_blank = blank[k];
            end
        end
        seg     = cur_blank ? 7'h00 : seg_decode(cur_nib);
        dig_sel = DIGITS'(1) << idx_q;
        bcd_out = bcd_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            bin_q   <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_sqrt_result_display.sv
// Scoreboard bench for sqrt_result_display: the driver queues expected commits,
// a negedge monitor checks commits, latency and the scanned display every cycle.
module tb_sqrt_result_display;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 3;
    localparam int unsigned SD = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             busy;
    logic [4*D-1:0]   bcd_out;
    logic [6:0]       seg;
    logic [D-1:0]     dig_sel;

    always #5 clk = ~clk;

    sqrt_result_display_if #(.WIDTH(W)) ifc ();

    sqrt_result_display #(
        .WIDTH    (W),
        .DIGITS   (D),
        .SCAN_DIV (SD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .res     (ifc.slave),
        .busy    (busy),
        .bcd_out (bcd_out),
        .seg     (seg),
        .dig_sel (dig_sel)
    );

    typedef struct {
        int unsigned val;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int unsigned n = 0;
    bit          rst_edge = 1'b0;
    bit          alive = 1'b0;
    bit          busy_prev = 1'b0;
    int unsigned disp_val = 0;

    logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic int unsigned pow10(input int unsigned k);
        int unsigned p = 1;
        for (int i = 0; i < int'(k); i++) p = p * 10;
        return p;
    endfunction

    function automatic int unsigned to_bcd(input int unsigned v);
        int unsigned r = 0;
        for (int k = 0; k < int'(D); k++) r = r | (((v / pow10(k)) % 10) << (4 * k));
        return r;
    endfunction

    function automatic int unsigned exp_seg(input int unsigned v, input int unsigned idx);
        if (idx > 0 && v < pow10(idx)) return 0;
        return int'(seg_tbl[(v / pow10(idx)) % 10]);
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // n counts clean edges since the last reset edge, which fixes the scan position.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= !rst_n;
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_edge) begin
            sb.delete();
            disp_val  = 0;
            busy_prev = 1'b0;
            alive     = 1'b1;
            chk("rst_bcd_out", int'(bcd_out), 0);
            chk("rst_ready", int'(ifc.res_ready), 1);
            chk("rst_busy", int'(busy), 0);
            chk("rst_dig_sel", int'(dig_sel), 1);
            chk("rst_seg", int'(seg), 32'h3F);
        end else if (alive) begin
            if (ifc.res_ready && busy_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_commit", int'(bcd_out), 32'hFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("commit_bcd", int'(bcd_out), to_bcd(e.val));
                    chk("commit_cycle", cyc, e.cyc);
                    disp_val = e.val;
                end
            end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
                e = sb.pop_front();
                chk("commit_timeout", cyc, e.cyc);
            end
            busy_prev = busy;
            chk("ready_vs_busy", int'(ifc.res_ready), int'(!busy));
            chk("dig_sel", int'(dig_sel), 1 << ((n >> SD) % D));
            chk("seg", int'(seg), exp_seg(disp_val, (n >> SD) % D));
        end
    end

    // Acceptance is decided from ready seen between edges; hold=0 gives a one-cycle pulse.
    task automatic drive(input int unsigned v, input bit hold);
        int k = 0;
        @(negedge clk);
        #1;
        ifc.res_data  = W'(v);
        ifc.res_valid = 1'b1;
        while (!ifc.res_ready && hold && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (ifc.res_ready) sb.push_back('{v, cyc + W + 2});
        else if (hold) chk("hold_timeout", 0, 1);
        @(negedge clk);
        #1;
        ifc.res_valid = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned extra);
        int k = 0;
        while (!ifc.res_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (extra) @(negedge clk);
    endtask

    initial begin
        int k;
        ifc.res_data  = '0;
        ifc.res_valid = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        drive(255, 1'b0);
        wait_idle(4);
        drive(15, 1'b0);
        wait_idle(16);
        drive(0, 1'b0);
        wait_idle(16);

        drive(100, 1'b0);
        drive(7, 1'b0);
        drive(7, 1'b1);
        wait_idle(4);

        drive(99, 1'b0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        wait_idle(6);

        drive(123, 1'b0);
        wait_idle(16);

        for (int i = 0; i < 20; i++) begin
            drive($urandom_range(0, 255), 1'b1);
            if ($urandom_range(0, 3) == 0) drive($urandom_range(0, 255), 1'b0);
            wait_idle($urandom_range(0, 14));
        end

        k = 0;
        while (sb.size() > 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        #1;
        chk("drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
